// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one byte-wide UART transmitter between NREQ
// requesters. Round-robin grant, per-grant burst limit, and a fixed settle
// delay after each write before UART_TXRDY is trusted again.
module uart_tx_arbiter #(
   parameter int NREQ      = 4,
   parameter int SETTLE    = 2,
   parameter int MAX_BURST = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              enable_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [8*NREQ-1:0] data_i,
   input  logic [NREQ-1:0]   last_i,
   output logic [NREQ-1:0]   ack_o,
   output logic [NREQ-1:0]   gnt_o,
   output logic              busy_o,
   output logic              uart_csn_o,
   output logic              uart_wen_o,
   output logic [7:0]        uart_data_o,
   input  logic              uart_txrdy_i
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW = 3;  // holds SETTLE-1 for SETTLE up to 7

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_WRITE,
      S_SETTLE,
      S_WAIT_RDY
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       gidx_q, gidx_d;   // index of the granted requester
   logic [IW-1:0]       ptr_q, ptr_d;     // last winner
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [7:0]          burst_q, burst_d;
   logic                last_q, last_d;   // LAST captured with the written byte
   logic [SW-1:0]       scnt_q, scnt_d;
   logic [7:0]          udata_q, udata_d; // byte held on the UART bus

   logic [NREQ-1:0][7:0] data_arr;
   logic [7:0]           sel_data;
   logic                 sel_last;
   logic                 sel_req;
   logic                 win_vld;
   logic [IW-1:0]        win_idx;
   logic [IW-1:0]        cand;
   logic                 burst_hit;

   assign data_arr  = data_i;
   assign sel_data  = data_arr[gidx_q];
   assign sel_last  = last_i[gidx_q];
   assign sel_req   = req_i[gidx_q];
   assign burst_hit = (MAX_BURST != 0) && (burst_q == 8'(MAX_BURST));
   assign gnt_o     = gnt_q;
   assign busy_o    = (state_q != S_IDLE);

   // round-robin search: first requesting index after the last winner
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(ptr_q) + k) % NREQ);
         if (!win_vld && req_i[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // next-state and output decode
   always_comb begin
      state_d     = state_q;
      gidx_d      = gidx_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      burst_d     = burst_q;
      last_d      = last_q;
      scnt_d      = scnt_q;
      udata_d     = udata_q;
      ack_o       = '0;
      uart_csn_o  = 1'b1;
      uart_wen_o  = 1'b1;
      uart_data_o = udata_q;
      case (state_q)
         S_IDLE: begin
            if (enable_i && win_vld) begin
               gidx_d         = win_idx;
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               state_d        = S_GRANT;
            end
         end
         S_GRANT: begin
            // requester withdrew before its byte was taken: give up the grant
            if (!sel_req) begin
               gnt_d   = '0;
               burst_d = '0;
               ptr_d   = gidx_q;
               state_d = S_IDLE;
            end else if (uart_txrdy_i) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            uart_csn_o  = 1'b0;
            uart_wen_o  = 1'b0;
            uart_data_o = sel_data;
            ack_o       = gnt_q;
            udata_d     = sel_data;
            last_d      = sel_last;
            burst_d     = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
            scnt_d      = '0;
            state_d     = S_SETTLE;
         end
         S_SETTLE: begin
            if (scnt_q == SW'(SETTLE - 1)) state_d = S_WAIT_RDY;
            else                           scnt_d  = scnt_q + SW'(1);
         end
         S_WAIT_RDY: begin
            if (uart_txrdy_i) begin
               if (last_q || !enable_i || burst_hit) begin
                  gnt_d   = '0;
                  burst_d = '0;
                  ptr_d   = gidx_q;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_GRANT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         gidx_q  <= '0;
         ptr_q   <= IW'(NREQ - 1);
         gnt_q   <= '0;
         burst_q <= '0;
         last_q  <= 1'b0;
         scnt_q  <= '0;
         udata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         scnt_q  <= scnt_d;
         udata_q <= udata_d;
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the UART transmitter (2..8).
REQ-002 Parameter SETTLE, default 2, cycles the block waits after a write before sampling UART_TXRDY (1..7).
REQ-003 Parameter MAX_BURST, default 16, maximum bytes per grant before forced re-arbitration; 0 = unlimited (1..255 otherwise).
REQ-004 CLK  in  1  the single clock; all logic on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 ENABLE  in  1  1 = arbitration permitted; 0 = no new grant issued.
REQ-007 REQ  in  NREQ  per-requester byte-valid request.
REQ-008 DATA  in  8*NREQ  per-requester byte; requester i uses bits 8i+7..8i.
REQ-009 LAST  in  NREQ  per-requester end-of-message flag, qualified with REQ.
REQ-010 ACK  out  NREQ  one-cycle pulse: the requester's current byte was written to the UART.
REQ-011 GNT  out  NREQ  one-hot grant; all-zero when idle.
REQ-012 BUSY  out  1  1 whenever the state is not IDLE.
REQ-013 UART_CSN  out  1  active-low UART chip select.
REQ-014 UART_WEN  out  1  active-low UART write enable.
REQ-015 UART_DATA  out  8  byte presented to the UART DATA_IN.
REQ-016 UART_TXRDY  in  1  UART transmit-ready status.

Function
REQ-017 The state machine SHALL have the states IDLE, GRANT, WRITE, SETTLE, WAIT_RDY.
REQ-018 IDLE: if ENABLE=1 and any REQ=1, select the winner round-robin starting at (last winner+1) mod NREQ; set GNT one-hot; go to GRANT; otherwise stay in IDLE.
REQ-019 GRANT: if UART_TXRDY=1 and REQ[g]=1 go to WRITE; if REQ[g]=0, clear GNT and go to IDLE; otherwise hold.
REQ-020 WRITE (exactly 1 cycle): UART_CSN=0, UART_WEN=0, UART_DATA=DATA[g], ACK[g]=1; latch LAST[g]; increment the burst counter; go to SETTLE.
REQ-021 SETTLE: count SETTLE cycles with UART_TXRDY ignored, then go to WAIT_RDY.
REQ-022 WAIT_RDY: hold while UART_TXRDY=0; when UART_TXRDY=1, release the grant if the latched LAST=1, ENABLE=0, or the burst count equals MAX_BURST (MAX_BURST>0), else return to GRANT with the same grant.
REQ-023 Releasing the grant SHALL clear GNT and the burst counter, record g as the last winner, and go to IDLE.
REQ-024 Outside WRITE: UART_CSN=1, UART_WEN=1, UART_DATA holds the last written byte, and ACK=0.
REQ-025 Best-case throughput: one byte per (3+SETTLE) cycles plus the UART_TXRDY wait.
REQ-026 Minimum release-to-new-grant gap SHALL be 1 cycle (the IDLE cycle).
REQ-027 Simultaneous requests: round-robin order only; no fixed priority other than the post-reset pointer.
REQ-028 A requester SHALL NOT be granted twice in a row while another REQ is pending at the IDLE decision.
REQ-029 ENABLE falling mid-burst: the in-flight byte completes (WRITE, SETTLE, WAIT_RDY), then the grant is released.
REQ-030 REQ[g] falling during SETTLE or WAIT_RDY is ignored until GRANT is re-entered.
REQ-031 DATA/LAST changes on non-granted requesters SHALL have no effect.
REQ-032 Burst counter: 8 bits; saturates at 255 when MAX_BURST=0.

Reset
REQ-033 When RESET=1 at a clock edge: state=IDLE; GNT=0; ACK=0; BUSY=0; UART_CSN=1; UART_WEN=1; UART_DATA=8'h00; burst counter=0; last-winner pointer=NREQ-1 (so requester 0 is granted first).
REQ-034 RESET mid-write SHALL abort at once, with no further ACK; a UART write already issued is not retracted.

Verification
REQ-035 After reset, REQ=4'b1111 with LAST=1 everywhere and TXRDY always 1 -> grants 0,1,2,3,0 in order; one ACK per grant; one WEN low pulse each; UART_DATA matches DATA of the granted requester.
REQ-036 Requester 2 streams 5 bytes (LAST on byte 5) while requester 0 also requests -> GNT stays 4'b0100 for 5 ACKs, then moves to 4'b0001.
REQ-037 MAX_BURST=3, requester 1 with LAST never set, requester 3 also requesting -> after 3 ACKs the grant moves to requester 3, then returns to requester 1.
REQ-038 UART_TXRDY held 0 for 40 cycles after a write -> no second WEN pulse until TXRDY=1 plus one GRANT cycle; WRITE never occurs earlier than SETTLE+1 cycles after the previous WRITE.
REQ-039 ENABLE dropped during SETTLE of byte 2 in a 4-byte burst -> byte 2 completes, grant released, no further grant while ENABLE=0; after ENABLE=1, arbitration resumes at the next requester.
REQ-040 RESET asserted in WAIT_RDY -> the next cycle shows GNT=0, BUSY=0, CSN=WEN=1; the subsequent grant goes to requester 0.
